// File: rtl/bias_loader.sv
// Purpose: fetch up to ARRAY_N bias words from word-addressed memory and write them into the SIMD bias register file.
// Latency: 3 cycles per bias with immediate grant and 1-cycle read data; done one cycle after the last write.
// Backpressure: a request holds its address until mem_gnt; each gnt or rvalid stall adds one cycle; one read outstanding.
module bias_loader #(
  parameter  int ARRAY_N    = 16,
  parameter  int OUT_WIDTH  = 32,
  parameter  int ADDR_WIDTH = 16,
  localparam int CW         = $clog2(ARRAY_N) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CW-1:0]         count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic [OUT_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_rvalid,
  output logic [CW-1:0]         w_index,
  output logic [OUT_WIDTH-1:0]  w_data,
  output logic                  w_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  logic [ADDR_WIDTH-1:0]   base_q;    // address of bias[0] for the current load
  logic [CW-1:0]           cnt_q;     // clamped number of biases to load
  logic [CW-1:0]           idx_q;     // index of the bias currently being fetched
  logic [ADDR_WIDTH-1:0]   addr_q;    // registered request address, stable across gnt stalls
  logic [CW-1:0]           w_index_q; // holds across cycles without w_en
  logic [OUT_WIDTH-1:0]    w_data_q;  // latched read word, holds across cycles without w_en

  logic [CW-1:0]           cnt_in;    // count clamped to the number of lanes
  logic                    last;      // current write is the final bias of the load
  logic [CW-1:0]           idx_nxt;

  // Clamp the requested count so w_index can never run past the last lane.
  always_comb begin
    cnt_in = count;
    if (count > CW'(ARRAY_N)) begin
      cnt_in = CW'(ARRAY_N);
    end
  end

  assign last    = (idx_q == cnt_q - CW'(1));
  assign idx_nxt = idx_q + CW'(1);

  // State register; reset aborts any load in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs decoded from the current state.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    mem_req = (state_q == S_REQ);
    w_en    = (state_q == S_WRITE);
    case (state_q)
      S_IDLE: begin
        // start is only honoured here, so starts while busy or in DONE are dropped
        if (start) begin
          state_d = (cnt_in == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last ? S_DONE : S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load parameters, walk the index/address, and capture read data for the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      w_index_q <= '0;
      w_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= cnt_in;
            idx_q  <= '0;
            // leave the address bus untouched for an empty load that never requests
            if (cnt_in != '0) begin
              addr_q <= base_addr;
            end
          end
        end
        S_WAIT: begin
          // rvalid outside WAIT never reaches here, so stray responses are dropped
          if (mem_rvalid) begin
            w_data_q  <= mem_rdata;
            w_index_q <= idx_q;
          end
        end
        S_WRITE: begin
          if (!last) begin
            idx_q  <= idx_nxt;
            // wraps modulo 2^ADDR_WIDTH by truncation
            addr_q <= base_q + ADDR_WIDTH'(idx_nxt);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr = addr_q;
  assign w_index  = w_index_q;
  assign w_data   = w_data_q;

endmodule

// File: tb/tb_bias_loader.sv
// Bench for bias_loader: directed cases followed by randomized loads.
// A memory responder with configurable grant/read latency serves requests; a monitor logs the write port.
// Expected writes, addresses and timing come from a per-load arithmetic model of the load rules.
module tb_bias_loader;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int AW = 16;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, mem_req, w_en;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt, mem_rvalid;
  logic [W-1:0]  mem_rdata, w_data;
  logic [CW-1:0] w_index;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bias_loader #(.ARRAY_N(N), .OUT_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .w_index(w_index), .w_data(w_data), .w_en(w_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory contents: mem[a] = a*3
  function automatic logic [W-1:0] mem_val(input logic [AW-1:0] a);
    return W'(a) * 32'd3;
  endfunction

  // ---------------- memory responder ----------------
  int            gnt_lat = 0;
  int            rv_lat  = 1;
  bit            spur    = 1'b0;
  int            wait_n  = 0;
  int            rv_n    = 0;
  bit            rv_pend = 1'b0;
  logic [AW-1:0] rv_addr = '0;
  logic [AW-1:0] gq[$];

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (reset) begin
      wait_n  = 0;
      rv_pend = 1'b0;
    end else begin
      if (rv_pend) begin
        if (rv_n <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_val(rv_addr);
          rv_pend    = 1'b0;
        end else begin
          rv_n--;
        end
      end
      if (mem_req) begin
        if (wait_n >= gnt_lat) begin
          mem_gnt = 1'b1;
          wait_n  = 0;
          rv_pend = 1'b1;
          rv_n    = rv_lat;
          rv_addr = mem_addr;
          gq.push_back(mem_addr);
        end else begin
          wait_n++;
          if (spur) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  int            wr_cyc[$];
  int            wr_idx[$];
  logic [W-1:0]  wr_dat[$];
  int            done_n = 0, done_cyc = -1, busy_n = 0, busy_first = -1, req_n = 0, addr_bad = 0;
  logic          prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (w_en) begin
      wr_cyc.push_back(cyc);
      wr_idx.push_back(int'(w_index));
      wr_dat.push_back(w_data);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy) begin
      busy_n++;
      if (busy_first < 0) busy_first = cyc;
    end
    if (mem_req) begin
      req_n++;
      if (prev_req && mem_addr !== prev_addr) addr_bad++;
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    wr_cyc.delete(); wr_idx.delete(); wr_dat.delete(); gq.delete();
    done_n = 0; done_cyc = -1; busy_n = 0; busy_first = -1; req_n = 0; addr_bad = 0;
  endtask

  // One load: cycle 0 is the cycle start is presented; each bias costs gl+rl+2 cycles.
  task automatic run_load(input logic [AW-1:0] b, input int c, input int gl, input int rl,
                          input bit sp, input bit stray, input string tag);
    int n, p, t0, guard, rel;
    logic [AW-1:0] a;
    n = (c > N) ? N : c;
    p = gl + rl + 2;
    gnt_lat = gl; rv_lat = rl; spur = sp;
    clear_mon();
    @(negedge clk);
    base_addr = b; count = CW'(c); start = 1'b1; t0 = cyc;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      rel = cyc - t0;
      start = stray && rel >= 1 && rel <= n * p + 1 && ((rel % 4) == 1 || rel == n * p + 1);
      if (start) begin
        base_addr = AW'($urandom);
        count     = CW'($urandom_range(1, 20));
      end
    end while (!done && guard < 3000);
    start = 1'b0;
    chk({tag, " done reached"}, done, 1);
    repeat (3) @(negedge clk);
    chk({tag, " n writes"}, wr_cyc.size(), n);
    for (int k = 0; k < n && k < wr_cyc.size(); k++) begin
      a = b + AW'(k);
      chk($sformatf("%s idx%0d", tag, k), wr_idx[k], k);
      chk($sformatf("%s data%0d", tag, k), wr_dat[k], mem_val(a));
      chk($sformatf("%s wcyc%0d", tag, k), wr_cyc[k] - t0, (k + 1) * p);
      if (k < gq.size()) chk($sformatf("%s addr%0d", tag, k), gq[k], a);
    end
    chk({tag, " n grants"}, gq.size(), n);
    chk({tag, " done count"}, done_n, 1);
    chk({tag, " done cycle"}, done_cyc - t0, n * p + 1);
    chk({tag, " busy cycles"}, busy_n, n * p + 1);
    chk({tag, " busy first"}, busy_first - t0, 1);
    chk({tag, " req cycles"}, req_n, n * (gl + 1));
    chk({tag, " addr stable"}, addr_bad, 0);
  endtask

  initial begin
    int wc, guard;
    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst w_en", w_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst w_index", w_index, 0);
    chk("rst w_data", w_data, 0);
    reset = 1'b0;

    run_load(16'h0100, 4, 0, 1, 1'b0, 1'b0, "basic");
    run_load(16'h0200, 0, 0, 1, 1'b0, 1'b0, "count0");
    run_load(16'h0040, 20, 0, 1, 1'b0, 1'b0, "clamp");
    run_load(16'h0100, 4, 5, 3, 1'b0, 1'b0, "stall");
    run_load(16'h0100, 4, 2, 1, 1'b1, 1'b1, "stray");

    // reset after the second write aborts the load
    gnt_lat = 0; rv_lat = 1; spur = 1'b0;
    clear_mon();
    @(negedge clk);
    base_addr = 16'h0100; count = CW'(4); start = 1'b1;
    wc = 0; guard = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      if (w_en) wc++;
      guard++;
    end while (wc < 2 && guard < 100);
    chk("abort saw 2 writes", wc, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort mem_req", mem_req, 0);
    chk("abort w_en", w_en, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort w_index", w_index, 0);
    chk("abort w_data", w_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort no done", done_n, 0);
    chk("abort writes total", wr_cyc.size(), 2);
    chk("abort idle", busy, 0);

    run_load(16'h0100, 4, 0, 1, 1'b0, 1'b0, "post-reset");
    run_load(16'hFFFE, 4, 0, 1, 1'b0, 1'b0, "wrap");

    for (int r = 0; r < 8; r++) begin
      run_load(AW'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
